icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 16 sets, direct-mapped, one 32-bit word per frame.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  instruction byte address; word-aligned.
REQ-006 ihit  output  1  requested word valid on imemload this cycle.
REQ-007 imemload  output  32  instruction word.
REQ-008 iREN  output  1  memory-side read request.
REQ-009 iaddr  output  32  memory-side word address.
REQ-010 iwait  input  1  memory busy; iwait low while iREN high completes the read that cycle.
REQ-011 iload  input  32  memory read data, valid when iREN high and iwait low.

Function
REQ-012 Address split: offset [1:0] ignored, index [5:2], tag [31:6] (26 bits).
REQ-013 Each frame holds valid (1b), tag (26b) and data (32b).
REQ-014 FSM states: IDLE, FETCH.
REQ-015 IDLE: ihit = imemREN & valid[index] & (tag[index] == imemaddr[31:6]), combinational, zero-cycle hit latency; imemload = data[index] when ihit, else 0.
REQ-016 IDLE with imemREN high and no hit: latch imemaddr into miss_addr, go to FETCH next cycle; ihit stays 0.
REQ-017 IDLE with imemREN low: iREN = 0, ihit = 0, no state change.
REQ-018 FETCH: iREN = 1, iaddr = {miss_addr[31:2], 2'b00}; ihit = 0.
REQ-019 FETCH and iwait high: remain in FETCH, no frame written.
REQ-020 FETCH and iwait low: write iload, valid = 1, tag = miss_addr[31:6] into frame miss_addr[5:2] at the clock edge, then go to IDLE.
REQ-021 Miss latency: hit reported the cycle after the fill edge when imemaddr is unchanged; total = memory wait cycles + 2.
REQ-022 A fill SHALL complete even if imemREN drops or imemaddr changes during FETCH; the fill uses miss_addr only.
REQ-023 A fill into an occupied valid frame SHALL overwrite it (conflict eviction); no write-back.
REQ-024 ihit SHALL never be asserted in FETCH, including for a different address that would hit.
REQ-025 The cache is read-only; no path writes cached data except a fill.

Reset
REQ-026 RST high at a clock edge: all valid bits = 0, FSM = IDLE, miss_addr = 0; tag/data contents need not be cleared.
REQ-027 Outputs during and after reset: ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
REQ-028 RST asserted mid-FETCH aborts the fill: no frame written, iREN = 0 the following cycle.

Configuration
REQ-029 Macro ICACHE_STATS_EN, when defined, adds outputs hit_count (16b) and miss_count (16b): hit_count increments each cycle ihit is 1; miss_count increments on each IDLE->FETCH transition; both saturate at 0xFFFF and reset to 0.
REQ-030 Without ICACHE_STATS_EN those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset, then imemREN=1, imemaddr=0x00000040, memory iwait=1 for 3 cycles then 0 with iload=0xDEADBEEF -> iREN high 4 cycles, iaddr=0x00000040, ihit=1 with imemload=0xDEADBEEF the cycle after fill.
REQ-032 After REQ-031, read 0x00000080 (same index 0, new tag) -> miss, fill; re-read 0x00000040 -> miss again (eviction confirmed).
REQ-033 Fill 16 addresses 0x0..0x3C, then read all 16 -> ihit=1 in the same cycle for each, iREN never asserted.
REQ-034 Miss on 0x100, change imemaddr to a cached address during FETCH -> ihit stays 0 until fill of 0x100 completes; frame 0 holds tag of 0x100.
REQ-035 RST asserted during FETCH with iwait=1 -> iREN=0 next cycle; subsequent read of same address misses.
REQ-036 With ICACHE_STATS_EN: 3 misses and 5 hit cycles -> miss_count=3, hit_count=5; force 70000 hit cycles -> hit_count holds 0xFFFF.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, 16-frame, one-word-per-frame read-only instruction cache.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] valid_q;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];
  logic [29:0] miss_addr_q, miss_addr_d;   // word address of the outstanding miss

  logic [3:0]  lookup_index;
  logic [3:0]  fill_index;
  logic        lookup_hit;
  logic        fill_en;
  logic        miss_start;
  logic        unused_offset;

  assign lookup_index  = imemaddr[5:2];
  assign fill_index    = miss_addr_q[3:0];
  assign lookup_hit    = valid_q[lookup_index] && (tag_q[lookup_index] == imemaddr[31:6]);
  assign unused_offset = ^imemaddr[1:0];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    fill_en     = 1'b0;
    miss_start  = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (imemREN) begin
            if (lookup_hit) begin
              ihit     = 1'b1;
              imemload = data_q[lookup_index];
            end else begin
              miss_addr_d = imemaddr[31:2];
              miss_start  = 1'b1;
              state_d     = FETCH;
            end
          end
        end
        FETCH: begin
          iREN  = 1'b1;
          iaddr = {miss_addr_q, 2'b00};
          if (!iwait) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) valid_q[fill_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_index]  <= miss_addr_q[29:4];
      data_q[fill_index] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ihit && (hit_count_q != 16'hFFFF))        hit_count_q  <= hit_count_q + 16'd1;
      if (miss_start && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: hit/miss latency, eviction, fill
// isolation during FETCH, reset abort, and (with ICACHE_STATS_EN) the counters.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  icache dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full miss: request, nwait busy cycles, fill, then the hit cycle.
  task automatic do_miss(input logic [31:0] addr, input int nwait, input logic [31:0] data);
    int ren_cycles;
    ren_cycles = 0;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = 32'h0;
    @(negedge CLK);
    check("miss_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    for (int k = 0; k <= nwait; k++) begin
      iwait = (k < nwait);
      iload = (k < nwait) ? 32'h0 : data;
      @(negedge CLK);
      if (iREN) ren_cycles++;
      check("fetch_iaddr", iaddr, {addr[31:2], 2'b00});
      check("fetch_ihit", {31'h0, ihit}, 32'h0);
      next_cycle();
    end
    iwait = 1'b1;
    iload = 32'h0;
    @(negedge CLK);
    check("iren_cycles", ren_cycles, nwait + 1);
    check("fill_ihit", {31'h0, ihit}, 32'h1);
    check("fill_data", imemload, data);
    check("fill_iren_low", {31'h0, iREN}, 32'h0);
    next_cycle();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    next_cycle();
    next_cycle();

    // Outputs while reset is held
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    @(negedge CLK);
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iren", {31'h0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    next_cycle();
    RST     = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("post_rst_iren", {31'h0, iREN}, 32'h0);
    check("post_rst_iaddr", iaddr, 32'h0);
    next_cycle();

    // Basic miss with three wait cycles
    do_miss(32'h40, 3, 32'hDEADBEEF);

    // Conflict eviction at index 0
    do_miss(32'h80, 1, 32'h11111111);
    do_miss(32'h40, 0, 32'hDEADBEEF);

    // Fill every frame, then read them all back as same-cycle hits
    for (int i = 0; i < 16; i++)
      do_miss(32'(i * 4), i % 3, 32'h1000_0000 + 32'(i * 32'h111));
    for (int i = 0; i < 16; i++) begin
      imemREN  = 1'b1;
      imemaddr = 32'(i * 4);
      @(negedge CLK);
      check("sweep_ihit", {31'h0, ihit}, 32'h1);
      check("sweep_data", imemload, 32'h1000_0000 + 32'(i * 32'h111));
      check("sweep_iren", {31'h0, iREN}, 32'h0);
      next_cycle();
    end

    // Miss on 0x100; a cached address during FETCH must not hit, and the fill uses 0x100
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    @(negedge CLK);
    check("m100_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    imemaddr = 32'h4;
    iwait    = 1'b1;
    @(negedge CLK);
    check("m100_fetch_ihit", {31'h0, ihit}, 32'h0);
    check("m100_fetch_iren", {31'h0, iREN}, 32'h1);
    check("m100_fetch_iaddr", iaddr, 32'h100);
    next_cycle();
    imemREN = 1'b0;
    iwait   = 1'b0;
    iload   = 32'hCAFEF00D;
    @(negedge CLK);
    check("m100_fill_ihit", {31'h0, ihit}, 32'h0);
    check("m100_fill_iren", {31'h0, iREN}, 32'h1);
    next_cycle();
    iwait    = 1'b1;
    iload    = 32'h0;
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    @(negedge CLK);
    check("m100_hit", {31'h0, ihit}, 32'h1);
    check("m100_data", imemload, 32'hCAFEF00D);
    imemaddr = 32'h4;
    #1;
    check("frame1_kept_ihit", {31'h0, ihit}, 32'h1);
    check("frame1_kept_data", imemload, 32'h1000_0111);
    imemaddr = 32'h0;
    #1;
    check("frame0_evicted", {31'h0, ihit}, 32'h0);
    imemaddr = 32'h100;
    next_cycle();

    // Reset during FETCH aborts the fill
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    @(negedge CLK);
    check("m200_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    @(negedge CLK);
    check("m200_fetch_iren", {31'h0, iREN}, 32'h1);
    next_cycle();
    RST   = 1'b1;
    iwait = 1'b0;
    iload = 32'hBAD0BAD0;
    next_cycle();
    iwait = 1'b1;
    iload = 32'h0;
    @(negedge CLK);
    check("abort_iren", {31'h0, iREN}, 32'h0);
    check("abort_iaddr", iaddr, 32'h0);
    check("abort_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    RST = 1'b0;
    do_miss(32'h200, 1, 32'h0000_0200);

`ifdef ICACHE_STATS_EN
    // Three misses (each followed by one hit cycle) plus two more hit cycles
    do_reset();
    imemREN = 1'b0;
    next_cycle();
    do_miss(32'h0, 0, 32'hA0A0_0000);
    do_miss(32'h4, 1, 32'hA0A0_0004);
    do_miss(32'h8, 2, 32'hA0A0_0008);
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    next_cycle();
    next_cycle();
    imemREN = 1'b0;
    @(negedge CLK);
    check("stat_miss_count", {16'h0, miss_count}, 32'd3);
    check("stat_hit_count", {16'h0, hit_count}, 32'd5);
    imemREN = 1'b1;
    for (int i = 0; i < 70000; i++) next_cycle();
    imemREN = 1'b0;
    @(negedge CLK);
    check("stat_hit_saturate", {16'h0, hit_count}, 32'h0000_FFFF);
    check("stat_miss_hold", {16'h0, miss_count}, 32'd3);
`else
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
